// File: rtl/matrix_alu_gen_if.sv
// Execution-engine bus for the matrix ALU: address/strobes/data out, result and status back.
interface matrix_alu_gen_if #(
  parameter int DIM = 4,
  parameter int EW  = 16
);
  logic [15:0]           address;
  logic                  nRead;
  logic                  nWrite;
  logic [DIM*DIM*EW-1:0] ExeDataOut;
  logic [DIM*DIM*EW-1:0] MatrixDataOut;
  logic                  Busy;
  logic                  Done;

  modport master (
    output address, nRead, nWrite, ExeDataOut,
    input  MatrixDataOut, Busy, Done
  );

  modport slave (
    input  address, nRead, nWrite, ExeDataOut,
    output MatrixDataOut, Busy, Done
  );
endinterface

// File: rtl/matrix_alu_gen.sv
// DIMxDIM matrix ALU, element-serial datapath (one element or one MAC per cycle).
// Optional MATRIX_ALU_SAT_EN: signed elements with saturating ADD/SUB/SCALE/SCALEIMM/MUL.
module matrix_alu_gen #(
  parameter int         DIM     = 4,
  parameter int         EW      = 16,
  parameter logic [3:0] UNIT_ID = 4'h2
) (
  input logic             Clk,
  input logic             nReset,
  matrix_alu_gen_if.slave bus
);
  localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIM - 1);
`ifdef MATRIX_ALU_SAT_EN
  localparam int AW = EW + DIM + EW;
`else
  localparam int AW = EW;
`endif

  localparam logic [3:0] OP_MUL  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_TRN  = 4'd3;
  localparam logic [3:0] OP_SCL  = 4'd4;
  localparam logic [3:0] OP_SIMM = 4'd5;

  typedef logic [DIM-1:0][DIM-1:0][EW-1:0] mat_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_nxt;
  mat_t                  src1, src2, res, shadow, shadow_upd;
  logic [EW-1:0]         imm;
  logic [3:0]            op;
  logic [CW-1:0]         ri, cj, kk;
  logic [AW-1:0]         acc, acc_nxt;
  logic [EW-1:0]         elem;
  logic [DIM*DIM*EW-1:0] rdata;
  logic [EW-1:0]         a_ij, b_ij, a_ji, a_ik, b_kj, b_00;
  logic [3:0]            off;
  logic                  sel, wr, rd, busy, start, elem_end, last;
  logic                  unused_addr;

  assign off         = bus.address[3:0];
  assign sel         = (bus.address[15:12] == UNIT_ID) && (bus.nRead != bus.nWrite);
  assign wr          = sel && !bus.nWrite;
  assign rd          = sel && !bus.nRead;
  assign busy        = (state == RUN);
  assign start       = wr && (off == 4'd3) && (bus.address[7:4] <= OP_SIMM) && !busy;
  assign elem_end    = (op != OP_MUL) || (kk == LAST);
  assign last        = elem_end && (ri == LAST) && (cj == LAST);
  assign unused_addr = ^bus.address[11:8];

  assign bus.Busy          = busy;
  assign bus.Done          = (state == DONE);
  assign bus.MatrixDataOut = rdata;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    a_ij = src1[ri][cj];
    b_ij = src2[ri][cj];
    a_ji = src1[cj][ri];
    a_ik = src1[ri][kk];
    b_kj = src2[kk][cj];
    b_00 = src2[0][0];
  end

`ifdef MATRIX_ALU_SAT_EN
  logic signed [2*EW-1:0] sp_mac, sp_scl, sp_imm;

  function automatic logic [AW-1:0] sx1(input logic [EW-1:0] v);
    return {{(AW-EW){v[EW-1]}}, v};
  endfunction

  function automatic logic [AW-1:0] sx2(input logic [2*EW-1:0] v);
    return {{(AW-2*EW){v[2*EW-1]}}, v};
  endfunction

  // Clamp to signed EW range: upper bits must all equal the sign bit.
  function automatic logic [EW-1:0] sat(input logic [AW-1:0] v);
    if (!v[AW-1] && (|v[AW-2:EW-1]))  return {1'b0, {(EW-1){1'b1}}};
    if (v[AW-1] && !(&v[AW-2:EW-1])) return {1'b1, {(EW-1){1'b0}}};
    return v[EW-1:0];
  endfunction

  always_comb begin
    sp_mac  = $signed(a_ik) * $signed(b_kj);
    sp_scl  = $signed(a_ij) * $signed(b_00);
    sp_imm  = $signed(a_ij) * $signed(imm);
    acc_nxt = ((kk == '0) ? '0 : acc) + sx2(sp_mac);
    elem    = '0;
    case (op)
      OP_MUL:  elem = sat(acc_nxt);
      OP_ADD:  elem = sat(sx1(a_ij) + sx1(b_ij));
      OP_SUB:  elem = sat(sx1(a_ij) - sx1(b_ij));
      OP_TRN:  elem = a_ji;
      OP_SCL:  elem = sat(sx2(sp_scl));
      OP_SIMM: elem = sat(sx2(sp_imm));
      default: elem = '0;
    endcase
  end
`else
  logic [EW-1:0] p_mac, p_scl, p_imm;

  always_comb begin
    p_mac   = a_ik * b_kj;
    p_scl   = a_ij * b_00;
    p_imm   = a_ij * imm;
    acc_nxt = ((kk == '0) ? '0 : acc) + p_mac;
    elem    = '0;
    case (op)
      OP_MUL:  elem = acc_nxt;
      OP_ADD:  elem = a_ij + b_ij;
      OP_SUB:  elem = a_ij - b_ij;
      OP_TRN:  elem = a_ji;
      OP_SCL:  elem = p_scl;
      OP_SIMM: elem = p_imm;
      default: elem = '0;
    endcase
  end
`endif

  // Merged view lets the final element land in result on the same edge DONE is entered.
  always_comb begin
    shadow_upd         = shadow;
    shadow_upd[ri][cj] = elem;
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state  <= IDLE;
      src1   <= '0;
      src2   <= '0;
      res    <= '0;
      shadow <= '0;
      imm    <= '0;
      op     <= '0;
      ri     <= '0;
      cj     <= '0;
      kk     <= '0;
      acc    <= '0;
      rdata  <= '0;
    end else begin
      state <= state_nxt;
      if (wr && !busy) begin
        case (off)
          4'd0:    src1 <= bus.ExeDataOut;
          4'd1:    src2 <= bus.ExeDataOut;
          4'd4:    imm  <= bus.ExeDataOut[EW-1:0];
          default: ;
        endcase
      end
      if (start) begin
        op  <= bus.address[7:4];
        ri  <= '0;
        cj  <= '0;
        kk  <= '0;
        acc <= '0;
      end else if (busy) begin
        acc <= acc_nxt;
        if (!elem_end) begin
          kk <= kk + 1'b1;
        end else begin
          kk     <= '0;
          shadow <= shadow_upd;
          if (cj == LAST) begin
            cj <= '0;
            ri <= (ri == LAST) ? '0 : ri + 1'b1;
          end else begin
            cj <= cj + 1'b1;
          end
        end
        if (last) res <= shadow_upd;
      end
      if (rd && (off == 4'd2)) rdata <= res;
    end
  end
endmodule

// File: tb/tb_matrix_alu_gen.sv
// Directed bench for matrix_alu_gen (DIM=4, EW=16): ops, latency, busy lockout, reset abort.
module tb_matrix_alu_gen;
  localparam int DIM = 4;
  localparam int EW  = 16;
  localparam int W   = DIM*DIM*EW;
  localparam logic [3:0] UID = 4'h2;

  typedef logic [DIM-1:0][DIM-1:0][EW-1:0] mat_t;

  logic Clk = 1'b0;
  logic nReset = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  matrix_alu_gen_if #(.DIM(DIM), .EW(EW)) bus ();
  matrix_alu_gen #(.DIM(DIM), .EW(EW), .UNIT_ID(UID)) dut (
    .Clk(Clk), .nReset(nReset), .bus(bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic acc(input logic [15:0] a, input logic nr, input logic nw, input mat_t d);
    @(negedge Clk);
    bus.address = a; bus.nRead = nr; bus.nWrite = nw; bus.ExeDataOut = d;
    @(negedge Clk);
    bus.nRead = 1'b1; bus.nWrite = 1'b1; bus.address = '0;
  endtask

  task automatic wr(input logic [3:0] off, input logic [3:0] opc, input mat_t d);
    acc({UID, 4'h0, opc, off}, 1'b1, 1'b0, d);
  endtask

  task automatic rd(output mat_t d);
    acc({UID, 12'h002}, 1'b0, 1'b1, '0);
    d = bus.MatrixDataOut;
  endtask

  // START, then count cycles to Done (START cycle is cycle 0) and Busy cycles.
  task automatic run(input logic [3:0] opc, input int lat, input string tag);
    int cyc, bsy;
    wr(4'h3, opc, '0);
    cyc = 1; bsy = 0;
    while (bus.Done !== 1'b1 && cyc < 300) begin
      if (bus.Busy === 1'b1) bsy++;
      @(negedge Clk);
      cyc++;
    end
    chk({tag, " latency"}, W'(cyc), W'(lat));
    chk({tag, " busy cycles"}, W'(bsy), W'(lat - 1));
    @(negedge Clk);
    chk({tag, " done pulse"}, W'({bus.Busy, bus.Done}), '0);
  endtask

  initial begin
    mat_t seq, idm, one, m, e, got;
    int   n;
    bus.address = '0; bus.nRead = 1'b1; bus.nWrite = 1'b1; bus.ExeDataOut = '0;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        seq[i][j] = EW'(i*4 + j);
        idm[i][j] = (i == j) ? EW'(1) : EW'(0);
        one[i][j] = EW'(1);
      end

    repeat (3) @(negedge Clk);
    chk("reset rdata", bus.MatrixDataOut, '0);
    chk("reset busy/done", W'({bus.Busy, bus.Done}), '0);
    nReset = 1'b1;

    // ADD basic
    wr(4'h0, 4'h0, one); wr(4'h1, 4'h0, seq);
    run(4'h1, 17, "add");
    rd(got);
    for (int i = 0; i < DIM; i++) for (int j = 0; j < DIM; j++) e[i][j] = EW'(i*4 + j + 1);
    chk("add result", got, e);

    // ADD wrap / saturation
    for (int i = 0; i < DIM; i++) for (int j = 0; j < DIM; j++) begin
      m[i][j] = 16'hFFFF; e[i][j] = 16'h0002;
    end
    wr(4'h0, 4'h0, m); wr(4'h1, 4'h0, e);
    run(4'h1, 17, "add ffff");
    rd(got);
    for (int i = 0; i < DIM; i++) for (int j = 0; j < DIM; j++) e[i][j] = 16'h0001;
    chk("add ffff+2", got, e);
    for (int i = 0; i < DIM; i++) for (int j = 0; j < DIM; j++) m[i][j] = 16'h7FFF;
    wr(4'h0, 4'h0, m);
    run(4'h1, 17, "add 7fff");
    rd(got);
`ifdef MATRIX_ALU_SAT_EN
    for (int i = 0; i < DIM; i++) for (int j = 0; j < DIM; j++) e[i][j] = 16'h7FFF;
`else
    for (int i = 0; i < DIM; i++) for (int j = 0; j < DIM; j++) e[i][j] = 16'h8001;
`endif
    chk("add 7fff+2", got, e);

    // MUL identity and general
    wr(4'h0, 4'h0, idm); wr(4'h1, 4'h0, seq);
    run(4'h0, 65, "mul id");
    rd(got);
    chk("mul id result", got, seq);
    wr(4'h0, 4'h0, seq);
    run(4'h0, 65, "mul seq");
    rd(got);
    for (int i = 0; i < DIM; i++) for (int j = 0; j < DIM; j++)
      e[i][j] = EW'(96*i + 16*i*j + 56 + 6*j);
    chk("mul seq result", got, e);

    // SUB, TRANSPOSE, SCALE, SCALEIMM
    wr(4'h1, 4'h0, one);
    run(4'h2, 17, "sub");
    rd(got);
    for (int i = 0; i < DIM; i++) for (int j = 0; j < DIM; j++) e[i][j] = EW'(i*4 + j - 1);
    chk("sub result", got, e);
    run(4'h3, 17, "trn");
    rd(got);
    for (int i = 0; i < DIM; i++) for (int j = 0; j < DIM; j++) e[i][j] = EW'(j*4 + i);
    chk("transpose result", got, e);
    for (int i = 0; i < DIM; i++) for (int j = 0; j < DIM; j++) m[i][j] = EW'(9);
    m[0][0] = EW'(5);
    wr(4'h1, 4'h0, m);
    run(4'h4, 17, "scl");
    rd(got);
    for (int i = 0; i < DIM; i++) for (int j = 0; j < DIM; j++) e[i][j] = EW'(5*(i*4 + j));
    chk("scale result", got, e);
    m = '0; m[0][0] = EW'(3);
    wr(4'h4, 4'h0, m);
    run(4'h5, 17, "simm");
    rd(got);
    for (int i = 0; i < DIM; i++) for (int j = 0; j < DIM; j++) e[i][j] = EW'(3*(i*4 + j));
    chk("scaleimm result", got, e);

    // Writes and START ignored while busy; mid-run read returns previous result
    wr(4'h0, 4'h0, idm); wr(4'h1, 4'h0, seq);
    wr(4'h3, 4'h0, '0);
    wr(4'h0, 4'h0, '0);
    wr(4'h3, 4'h1, '0);
    rd(got);
    chk("midrun read", got, e);
    chk("midrun busy", W'(bus.Busy), W'(1));
    n = 0;
    while (bus.Done !== 1'b1 && n < 200) begin @(negedge Clk); n++; end
    chk("midrun done seen", W'(n < 200), W'(1));
    @(negedge Clk);
    rd(got);
    chk("mul after ignored writes", got, seq);
    run(4'h1, 17, "add src1 kept");
    rd(got);
    for (int i = 0; i < DIM; i++) for (int j = 0; j < DIM; j++) e[i][j] = EW'(i*4 + j + ((i == j) ? 1 : 0));
    chk("src1 kept result", got, e);

    // Wrong unit and double strobe are ignored
    acc({4'h3, 12'h000}, 1'b1, 1'b0, '0);
    acc({UID, 12'h000}, 1'b0, 1'b0, '0);
    run(4'h1, 17, "add ignored access");
    rd(got);
    chk("ignored access result", got, e);

    // Illegal opcode
    wr(4'h3, 4'h7, '0);
    n = 0;
    repeat (80) begin
      if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) n++;
      @(negedge Clk);
    end
    chk("op7 no activity", W'(n), '0);

    // Reset mid-run aborts
    wr(4'h0, 4'h0, one); wr(4'h1, 4'h0, seq);
    wr(4'h3, 4'h1, '0);
    repeat (4) @(negedge Clk);
    nReset = 1'b0;
    @(negedge Clk);
    nReset = 1'b1;
    chk("abort busy/done", W'({bus.Busy, bus.Done}), '0);
    n = 0;
    repeat (40) begin
      if (bus.Done !== 1'b0) n++;
      @(negedge Clk);
    end
    chk("abort no done", W'(n), '0);
    rd(got);
    chk("abort result", got, '0);
    wr(4'h0, 4'h0, one); wr(4'h1, 4'h0, seq);
    run(4'h1, 17, "add after reset");
    rd(got);
    for (int i = 0; i < DIM; i++) for (int j = 0; j < DIM; j++) e[i][j] = EW'(i*4 + j + 1);
    chk("add after reset result", got, e);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
